// File: rtl/mem_burst_ctrl_if.sv
// Command, write-data and read-response channels between a burst master and mem_burst_ctrl.
// Handshakes: a beat transfers on a rising clk edge where valid && ready; the source holds
// valid and payload until that edge, and ready may depend combinationally on valid.
interface mem_burst_ctrl_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [7:0]        cmd_len;
  logic              wdata_valid;
  logic              wdata_ready;
  logic [DATA_W-1:0] wdata;
  logic              rdata_valid;
  logic              rdata_ready;
  logic [DATA_W-1:0] rdata;
  logic              rdata_last;
  logic              done;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_len, wdata_valid, wdata, rdata_ready,
    input  cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last, done
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_len, wdata_valid, wdata, rdata_ready,
    output cmd_ready, wdata_ready, rdata_valid, rdata, rdata_last, done
  );
endinterface

// File: rtl/mem_burst_ctrl.sv
// Burst controller owning the we/addr/data_in port of an 8x256 registered-read memory.
// Read data returns through a 2-entry buffer that hides the memory latency under backpressure.
module mem_burst_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 8,
  parameter int RBUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  mem_burst_ctrl_if.slave   bus,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [1:0]        state_dbg
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state, state_nx;
  logic [ADDR_W-1:0] cur_addr;
  logic [7:0]        beats_left;
  logic              inflight, inflight_last;
  logic [DATA_W-1:0] fifo_data [RBUF_DEPTH];
  logic              fifo_last [RBUF_DEPTH];
  logic              rd_ptr, wr_ptr;
  logic [1:0]        fifo_count;
  logic              done_q, done_nx;
  logic              cmd_hs, wr_hs, issue, push, pop, head_last;
  logic [2:0]        occupancy, limit;

  assign push      = inflight;
  assign head_last = fifo_last[rd_ptr];
  assign pop       = bus.rdata_valid && bus.rdata_ready;

  assign bus.rdata_valid = !rst && (fifo_count != 2'd0);
  assign bus.rdata       = fifo_data[rd_ptr];
  assign bus.rdata_last  = bus.rdata_valid && head_last;
  assign bus.done        = done_q;
  assign state_dbg       = state;

  always_comb begin
    state_nx        = state;
    done_nx         = 1'b0;
    cmd_hs          = 1'b0;
    wr_hs           = 1'b0;
    issue           = 1'b0;
    bus.cmd_ready   = 1'b0;
    bus.wdata_ready = 1'b0;
    mem_we          = 1'b0;
    mem_addr        = '0;
    mem_din         = '0;
    // A beat may issue when buffered + in-flight beats, less this cycle's pop, leave room.
    occupancy = {1'b0, fifo_count} + {2'b00, inflight};
    limit     = 3'(RBUF_DEPTH) + {2'b00, pop};
    if (!rst) begin
      unique case (state)
        IDLE: begin
          bus.cmd_ready = 1'b1;
          if (bus.cmd_valid) begin
            cmd_hs   = 1'b1;
            state_nx = bus.cmd_write ? WRITE : READ;
          end
        end
        WRITE: begin
          bus.wdata_ready = 1'b1;
          mem_addr        = cur_addr;
          mem_din         = bus.wdata;
          if (bus.wdata_valid) begin
            wr_hs  = 1'b1;
            mem_we = 1'b1;
            if (beats_left == 8'd0) begin
              state_nx = IDLE;
              done_nx  = 1'b1;
            end
          end
        end
        READ: begin
          mem_addr = cur_addr;
          if (occupancy < limit) begin
            issue = 1'b1;
            if (beats_left == 8'd0) state_nx = DRAIN;
          end
        end
        DRAIN: begin
          if (pop && head_last) begin
            state_nx = IDLE;
            done_nx  = 1'b1;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cur_addr      <= '0;
      beats_left    <= '0;
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
      rd_ptr        <= 1'b0;
      wr_ptr        <= 1'b0;
      fifo_count    <= 2'd0;
      done_q        <= 1'b0;
    end else begin
      state  <= state_nx;
      done_q <= done_nx;
      if (cmd_hs) begin
        cur_addr   <= bus.cmd_addr;
        beats_left <= bus.cmd_len;
      end else if (wr_hs || issue) begin
        cur_addr   <= cur_addr + ADDR_W'(1);
        beats_left <= beats_left - 8'd1;
      end
      // The memory returns data one cycle after the issue; tag it so the last beat is known.
      inflight      <= issue;
      inflight_last <= issue && (beats_left == 8'd0);
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
      fifo_count <= fifo_count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_data[wr_ptr] <= mem_dout;
      fifo_last[wr_ptr] <= inflight_last;
    end
  end
endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Bench for mem_burst_ctrl: cycle vector table for a basic write/read, then directed
// sequences for wrap, backpressure, write stalls, reset mid-burst and back-to-back commands.
module tb_mem_burst_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       mem_we;
  logic [7:0] mem_addr, mem_din, mem_dout;
  logic [1:0] state_dbg;

  mem_burst_ctrl_if #(.ADDR_W(8), .DATA_W(8)) bus ();

  mem_burst_ctrl #(.ADDR_W(8), .DATA_W(8), .RBUF_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .bus(bus), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

  // Registered-read memory the controller drives
  logic [7:0] mem_arr [256];
  always @(posedge clk) begin
    if (mem_we) mem_arr[mem_addr] <= mem_din;
    mem_dout <= mem_arr[mem_addr];
  end

  logic [7:0] ref_mem [256];
  logic [7:0] wbuf [256];
  logic [7:0] exp_q [$];
  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic r, cv, cw; logic [7:0] ca, cl; logic wv; logic [7:0] wd; logic rr;
    logic ecr, ewr, ewe, km; logic [7:0] ema; logic kd; logic [7:0] emd;
    logic erv, kr; logic [7:0] erd; logic erl, edn;
  } vec_t;
  vec_t vq [$];

  function automatic vec_t mk(input logic r, cv, cw, input logic [7:0] ca, cl, input logic wv,
                              input logic [7:0] wd, input logic rr, input logic ecr, ewr, ewe, km,
                              input logic [7:0] ema, input logic kd, input logic [7:0] emd,
                              input logic erv, kr, input logic [7:0] erd, input logic erl, edn);
    vec_t v;
    v.r = r; v.cv = cv; v.cw = cw; v.ca = ca; v.cl = cl; v.wv = wv; v.wd = wd; v.rr = rr;
    v.ecr = ecr; v.ewr = ewr; v.ewe = ewe; v.km = km; v.ema = ema; v.kd = kd; v.emd = emd;
    v.erv = erv; v.kr = kr; v.erd = erd; v.erl = erl; v.edn = edn;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic timeout(input string nm);
    n_checks++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", nm, $time);
  endtask

  task automatic send_cmd(input logic w, input logic [7:0] addr, input logic [7:0] len);
    bit ok = 0;
    bus.cmd_valid = 1'b1; bus.cmd_write = w; bus.cmd_addr = addr; bus.cmd_len = len;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      if (bus.cmd_ready) ok = 1;
      @(posedge clk); #1;
    end
    bus.cmd_valid = 1'b0;
    if (!ok) timeout("cmd_accept");
  endtask

  task automatic run_write(input logic [7:0] addr, input int nbeats, input int stall_at,
                           input int stall_len);
    logic [7:0] a = addr;
    int b = 0, s = 0;
    bit fin = 0, stalled;
    for (int c = 0; c < nbeats + stall_len + 5 && !fin; c++) begin
      stalled = 0;
      if (b < nbeats && b == stall_at && s < stall_len) begin
        stalled = 1; s++; bus.wdata_valid = 1'b0;
      end else if (b < nbeats) begin
        bus.wdata_valid = 1'b1; bus.wdata = wbuf[b];
      end else bus.wdata_valid = 1'b0;
      bus.rdata_ready = 1'b1;
      @(negedge clk);
      if (b == nbeats) begin
        chk("wr_done", bus.done, 1);
        chk("wr_done_cmd_ready", bus.cmd_ready, 1);
        chk("wr_done_we", mem_we, 0);
        fin = 1;
      end else begin
        chk("wr_ready", bus.wdata_ready, 1);
        chk("wr_no_early_done", bus.done, 0);
        chk("wr_no_rvalid", bus.rdata_valid, 0);
        chk("wr_we", mem_we, !stalled);
        if (!stalled) begin
          chk("wr_addr", mem_addr, a);
          chk("wr_din", mem_din, wbuf[b]);
          ref_mem[a] = wbuf[b];
          a++; b++;
        end
      end
      @(posedge clk); #1;
    end
    bus.wdata_valid = 1'b0;
    if (!fin) timeout("wr_done");
  endtask

  // mode 0: rdata_ready always high; mode 1: ready pattern 1,0,0 repeating
  task automatic run_read(input logic [7:0] addr, input int nbeats, input int mode, output int edges);
    int first_v = -1;
    bit fin = 0, prev_stall = 0;
    exp_q.delete();
    for (int i = 0; i < nbeats; i++) exp_q.push_back(ref_mem[8'(addr + i)]);
    edges = -1;
    for (int c = 1; c <= 700 && !fin; c++) begin
      bus.rdata_ready = (mode == 0) ? 1'b1 : ((c % 3) == 1);
      bus.wdata_valid = 1'b1; bus.wdata = 8'hEE;
      @(negedge clk);
      chk("rd_we_ignored", mem_we, 0);
      if (bus.done) begin
        chk("rd_done_all_beats", exp_q.size(), 0);
        chk("rd_done_cmd_ready", bus.cmd_ready, 1);
        chk("rd_done_rvalid", bus.rdata_valid, 0);
        edges = c - 1; fin = 1;
      end else begin
        chk("rd_cmd_ready", bus.cmd_ready, 0);
        if (prev_stall) chk("rd_hold_valid", bus.rdata_valid, 1);
        if (bus.rdata_valid) begin
          if (first_v < 0) first_v = c - 1;
          if (exp_q.size() == 0) timeout("rd_extra_beat");
          else begin
            chk("rd_data", bus.rdata, exp_q[0]);
            chk("rd_last", bus.rdata_last, exp_q.size() == 1);
            if (bus.rdata_ready) void'(exp_q.pop_front());
          end
        end
        prev_stall = bus.rdata_valid && !bus.rdata_ready;
      end
      @(posedge clk); #1;
    end
    bus.rdata_ready = 1'b0; bus.wdata_valid = 1'b0;
    if (!fin) timeout("rd_done");
    if (mode == 0) chk("rd_first_latency", first_v, 2);
  endtask

  initial begin
    vec_t v;
    int e, pops;
    rst = 1'b1;
    bus.cmd_valid = 0; bus.cmd_write = 0; bus.cmd_addr = 0; bus.cmd_len = 0;
    bus.wdata_valid = 0; bus.wdata = 0; bus.rdata_ready = 0;

    // Reset, write 0x10..0x13 with A1..A4, read them back (wdata_valid ignored outside WRITE)
    vq.push_back(mk(1,0,0,8'h00,8'h00,0,8'h00,0, 0,0,0, 1,8'h00, 1,8'h00, 0,0,8'h00,0,0));
    vq.push_back(mk(0,1,1,8'h10,8'h03,0,8'h00,0, 1,0,0, 1,8'h00, 1,8'h00, 0,0,8'h00,0,0));
    vq.push_back(mk(0,0,0,8'h00,8'h00,1,8'hA1,0, 0,1,1, 1,8'h10, 1,8'hA1, 0,0,8'h00,0,0));
    vq.push_back(mk(0,0,0,8'h00,8'h00,1,8'hA2,0, 0,1,1, 1,8'h11, 1,8'hA2, 0,0,8'h00,0,0));
    vq.push_back(mk(0,0,0,8'h00,8'h00,1,8'hA3,0, 0,1,1, 1,8'h12, 1,8'hA3, 0,0,8'h00,0,0));
    vq.push_back(mk(0,0,0,8'h00,8'h00,1,8'hA4,0, 0,1,1, 1,8'h13, 1,8'hA4, 0,0,8'h00,0,0));
    vq.push_back(mk(0,1,0,8'h10,8'h03,1,8'h55,1, 1,0,0, 0,8'h00, 0,8'h00, 0,0,8'h00,0,1));
    vq.push_back(mk(0,0,0,8'h00,8'h00,1,8'h55,1, 0,0,0, 1,8'h10, 0,8'h00, 0,0,8'h00,0,0));
    vq.push_back(mk(0,0,0,8'h00,8'h00,1,8'h55,1, 0,0,0, 1,8'h11, 0,8'h00, 0,0,8'h00,0,0));
    vq.push_back(mk(0,0,0,8'h00,8'h00,0,8'h00,1, 0,0,0, 1,8'h12, 0,8'h00, 1,1,8'hA1,0,0));
    vq.push_back(mk(0,0,0,8'h00,8'h00,0,8'h00,1, 0,0,0, 1,8'h13, 0,8'h00, 1,1,8'hA2,0,0));
    vq.push_back(mk(0,0,0,8'h00,8'h00,0,8'h00,1, 0,0,0, 0,8'h00, 0,8'h00, 1,1,8'hA3,0,0));
    vq.push_back(mk(0,0,0,8'h00,8'h00,0,8'h00,1, 0,0,0, 0,8'h00, 0,8'h00, 1,1,8'hA4,1,0));
    vq.push_back(mk(0,0,0,8'h00,8'h00,0,8'h00,1, 1,0,0, 0,8'h00, 0,8'h00, 0,0,8'h00,0,1));
    vq.push_back(mk(0,0,0,8'h00,8'h00,0,8'h00,1, 1,0,0, 0,8'h00, 0,8'h00, 0,0,8'h00,0,0));

    for (int i = 0; i < vq.size(); i++) begin
      v = vq[i];
      rst = v.r; bus.cmd_valid = v.cv; bus.cmd_write = v.cw; bus.cmd_addr = v.ca;
      bus.cmd_len = v.cl; bus.wdata_valid = v.wv; bus.wdata = v.wd; bus.rdata_ready = v.rr;
      @(negedge clk);
      chk($sformatf("v%0d_cmd_ready", i), bus.cmd_ready, v.ecr);
      chk($sformatf("v%0d_wdata_ready", i), bus.wdata_ready, v.ewr);
      chk($sformatf("v%0d_mem_we", i), mem_we, v.ewe);
      chk($sformatf("v%0d_rdata_valid", i), bus.rdata_valid, v.erv);
      chk($sformatf("v%0d_rdata_last", i), bus.rdata_last, v.erl);
      chk($sformatf("v%0d_done", i), bus.done, v.edn);
      if (v.km) chk($sformatf("v%0d_mem_addr", i), mem_addr, v.ema);
      if (v.kd) chk($sformatf("v%0d_mem_din", i), mem_din, v.emd);
      if (v.kr) chk($sformatf("v%0d_rdata", i), bus.rdata, v.erd);
      @(posedge clk); #1;
    end
    bus.cmd_valid = 0; bus.wdata_valid = 0; bus.rdata_ready = 0;

    // Address wrap FE, FF, 00
    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    send_cmd(1'b1, 8'hFE, 8'd2);
    run_write(8'hFE, 3, -1, 0);
    send_cmd(1'b0, 8'hFE, 8'd2);
    run_read(8'hFE, 3, 0, e);
    chk("wrap_rd_edges", e, 5);

    // 256-beat write starting mid-range covers every address once
    for (int i = 0; i < 256; i++) wbuf[i] = 8'(i * 37 + 5);
    send_cmd(1'b1, 8'h9C, 8'd255);
    run_write(8'h9C, 256, -1, 0);

    // Backpressure read
    send_cmd(1'b0, 8'h40, 8'd7);
    run_read(8'h40, 8, 1, e);

    // Write with a 3-cycle stall before beat 2, then read back
    for (int i = 0; i < 6; i++) wbuf[i] = 8'hC0 + 8'(i);
    send_cmd(1'b1, 8'h80, 8'd5);
    run_write(8'h80, 6, 2, 3);
    send_cmd(1'b0, 8'h80, 8'd5);
    run_read(8'h80, 6, 0, e);
    chk("stall_rd_edges", e, 8);

    // Reset after two of eight read beats
    send_cmd(1'b0, 8'h20, 8'd7);
    bus.rdata_ready = 1'b1;
    pops = 0;
    for (int c = 0; c < 20 && pops < 2; c++) begin
      @(negedge clk);
      if (bus.rdata_valid) begin
        chk("rst_pre_data", bus.rdata, ref_mem[8'(8'h20 + pops)]);
        pops++;
      end
      @(posedge clk); #1;
    end
    if (pops < 2) timeout("rst_pre_beats");
    rst = 1'b1;
    @(negedge clk);
    chk("rst_cyc_rvalid", bus.rdata_valid, 0);
    chk("rst_cyc_cmd_ready", bus.cmd_ready, 0);
    chk("rst_cyc_we", mem_we, 0);
    chk("rst_cyc_done", bus.done, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("post_rst_rvalid", bus.rdata_valid, 0);
      chk("post_rst_rlast", bus.rdata_last, 0);
      chk("post_rst_done", bus.done, 0);
      chk("post_rst_cmd_ready", bus.cmd_ready, 1);
      chk("post_rst_we", mem_we, 0);
      @(posedge clk); #1;
    end
    bus.rdata_ready = 1'b0;
    send_cmd(1'b0, 8'h20, 8'd0);
    run_read(8'h20, 1, 0, e);
    chk("post_rst_single_edges", e, 3);

    // Full 256-beat read with the next command already held on the bus
    send_cmd(1'b0, 8'h37, 8'd255);
    bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0; bus.cmd_addr = 8'h05; bus.cmd_len = 8'd0;
    run_read(8'h37, 256, 0, e);
    chk("b2b_full_edges", e, 258);
    bus.cmd_valid = 1'b0;
    run_read(8'h05, 1, 0, e);
    chk("b2b_second_edges", e, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mem_burst_ctrl.md
Name: mem_burst_ctrl

Overview:
Burst access controller that sits directly upstream of the 8-bit x 256 memory_module and owns its we/addr/data_in port. It accepts read or write burst commands over a valid/ready interface, streams write data into the memory, and returns read data through a 2-entry response buffer. The buffer absorbs the memory's 1-cycle registered read latency under downstream backpressure. Address auto-increments per beat and wraps 255 -> 0.

Parameters:
ADDR_W, 8, memory address width; wrap modulo 2^ADDR_W
DATA_W, 8, data width
RBUF_DEPTH, 2, read response buffer entries; fixed at 2, minimum for full throughput

Ports:
clk  in  1  clock; all state updates on posedge
rst  in  1  synchronous reset, active-high
cmd_valid  in  1  command offered
cmd_ready  out  1  controller can accept a command
cmd_write  in  1  1 = write burst, 0 = read burst
cmd_addr  in  ADDR_W  burst start address
cmd_len  in  8  beats minus one (0 -> 1 beat, 255 -> 256 beats)
wdata_valid  in  1  write beat offered
wdata_ready  out  1  controller accepts write beat
wdata  in  DATA_W  write beat data
rdata_valid  out  1  read beat available
rdata_ready  in  1  consumer accepts read beat
rdata  out  DATA_W  read beat data
rdata_last  out  1  marks final beat of the read burst
done  out  1  1-cycle pulse when a burst completes
mem_we  out  1  to memory we
mem_addr  out  ADDR_W  to memory addr
mem_din  out  DATA_W  to memory data_in
mem_dout  in  DATA_W  from memory data_out; valid the cycle after mem_we=0 with mem_addr

Behaviour:
- States: IDLE, WRITE, READ, DRAIN. Registers: cur_addr, beats_left, inflight flag, 2-entry response FIFO with last bits, done register.
- rst high: next state IDLE; FIFO, inflight, and done cleared. Outputs during and after reset: cmd_ready=0 during reset cycle, then 1 (IDLE); wdata_ready=0, rdata_valid=0, rdata_last=0, done=0, mem_we=0, mem_addr=0, mem_din=0. Reset mid-burst aborts the burst: no further mem_we, buffered read data discarded, no done pulse.
- IDLE: cmd_ready=1. On cmd_valid&&cmd_ready, load cur_addr=cmd_addr and beats_left=cmd_len, then go to WRITE or READ. mem_we=0.
- WRITE: wdata_ready=1. mem_we = wdata_valid (combinational), mem_addr=cur_addr, mem_din=wdata, so the memory writes on the handshake edge.
  - Per handshake: cur_addr+1 mod 256, beats_left-1.
  - Handshake with beats_left==0 -> IDLE, done=1 next cycle.
  - wdata_valid low inserts stall cycles with mem_we=0.
- READ: issue a beat (mem_we=0, mem_addr=cur_addr) when fifo_count + inflight - pop < 2, where pop = rdata_valid&&rdata_ready.
  - Issue sets inflight for the next cycle. That next cycle pushes mem_dout into the FIFO with last = (issued beat was final).
  - Address/beat update as for WRITE. After issuing the final beat -> DRAIN.
- DRAIN: no issues. Go to IDLE on the pop of the last-tagged entry; done=1 next cycle.
- Response FIFO: rdata/rdata_last show the head entry. Push and pop in the same cycle are both honoured.
- Throughput: with rdata_ready held high, 1 beat/cycle. First rdata_valid appears 2 cycles after the cmd handshake edge: 1 cycle to issue, 1 cycle of memory latency.
- rdata_valid, once high, holds with stable rdata until popped.
- Single-beat and 256-beat bursts are legal. A 256-beat burst from addr A covers every address once and ends at A-1 mod 256.
- cmd_ready=0 in all states except IDLE. A new command is accepted no earlier than the cycle done is high.
- Inputs outside their active state are ignored: wdata_valid in READ/IDLE, rdata_ready when FIFO empty.

Test Plan:
- Reset then write burst addr=0x10, len=3, data 0xA1..0xA4, wdata_valid always high -> mem_we high 4 cycles at addrs 0x10..0x13; done pulses once; then read burst returns A1,A2,A3,A4 with rdata_last on 4th only.
- Wrap: write addr=0xFE, len=2, data 11,22,33 -> mem addrs FE,FF,00; read addr=0xFE len=2 returns 11,22,33.
- Backpressure: read len=7 with rdata_ready toggled 1,0,0,1,... -> no beat lost or duplicated, data in address order, FIFO never exceeds 2, rdata stable while stalled.
- Write stalls: wdata_valid low for 3 cycles mid-burst -> mem_we low during stall, beat count and addresses unaffected.
- Reset mid-read: rst high 1 cycle after 2 of 8 beats delivered -> rdata_valid=0 next cycle, no done, cmd_ready=1 after reset, new command then works normally.
- Back-to-back: second command presented with cmd_valid held -> accepted in the cycle done=1; full 256-beat read at rdata_ready=1 completes in 258 cycles from the cmd handshake.
